// File: rtl/arp_ctrl_if.sv
// Bundle of the ARP controller's receiver, lookup and transmitter-command signals.
// The environment drives through the master modport; the controller uses the slave modport.
interface arp_ctrl_if;
    localparam int unsigned IP_W  = 32;
    localparam int unsigned MAC_W = 48;
    localparam int unsigned OP_W  = 16;

    logic [MAC_W-1:0] i_rx_mac;
    logic [IP_W-1:0]  i_rx_ip;
    logic             i_rx_valid;
    logic             i_trig_reply;

    logic [IP_W-1:0]  i_lookup_ip;
    logic             i_lookup_valid;
    logic             o_lookup_ready;
    logic [MAC_W-1:0] o_lookup_mac;
    logic             o_lookup_done;
    logic             o_lookup_fail;

    logic             o_tx_valid;
    logic             i_tx_ready;
    logic [OP_W-1:0]  o_tx_op;
    logic [IP_W-1:0]  o_tx_dst_ip;
    logic [MAC_W-1:0] o_tx_dst_mac;

    modport master (
        output i_rx_mac, i_rx_ip, i_rx_valid, i_trig_reply,
        output i_lookup_ip, i_lookup_valid, i_tx_ready,
        input  o_lookup_ready, o_lookup_mac, o_lookup_done, o_lookup_fail,
        input  o_tx_valid, o_tx_op, o_tx_dst_ip, o_tx_dst_mac
    );

    modport slave (
        input  i_rx_mac, i_rx_ip, i_rx_valid, i_trig_reply,
        input  i_lookup_ip, i_lookup_valid, i_tx_ready,
        output o_lookup_ready, o_lookup_mac, o_lookup_done, o_lookup_fail,
        output o_tx_valid, o_tx_op, o_tx_dst_ip, o_tx_dst_mac
    );
endinterface

// File: rtl/arp_ctrl.sv
// ARP resolver: 4-entry IP->MAC cache, request/retry engine for misses, and
// reply scheduling that takes priority over outgoing requests.
module arp_ctrl #(
    parameter logic [31:0] P_RETRY_CYCLES = 32'd125_000_000,
    parameter int unsigned P_MAX_RETRY    = 3
) (
    input  logic      i_clk,
    input  logic      i_rst,
    arp_ctrl_if.slave io_arp
);
    localparam int unsigned LP_ENTRIES = 4;
    localparam int unsigned LP_PTR_W   = 2;
    localparam int unsigned LP_IP_W    = 32;
    localparam int unsigned LP_MAC_W   = 48;
    localparam int unsigned LP_OP_W    = 16;
    localparam int unsigned LP_TMR_W   = 32;
    localparam int unsigned LP_RTY_W   = 8;
    localparam logic [LP_OP_W-1:0]  LP_OP_REQ = 16'd1;
    localparam logic [LP_OP_W-1:0]  LP_OP_RPL = 16'd2;
    localparam logic [LP_MAC_W-1:0] LP_BCAST  = '1;

    typedef enum logic [2:0] {IDLE, CHECK, SEND_REQ, WAIT_RSP, SEND_RPL, DONE} state_t;

    state_t                r_state;
    state_t                r_ret;
    logic                  r_cache_v   [LP_ENTRIES];
    logic [LP_IP_W-1:0]    r_cache_ip  [LP_ENTRIES];
    logic [LP_MAC_W-1:0]   r_cache_mac [LP_ENTRIES];
    logic [LP_PTR_W-1:0]   r_ptr;
    logic [LP_IP_W-1:0]    r_ip;
    logic [LP_TMR_W-1:0]   r_timer;
    logic [LP_RTY_W-1:0]   r_retry;
    logic                  r_pending;
    logic                  r_rpl_new;
    logic [LP_IP_W-1:0]    r_rpl_ip;
    logic [LP_MAC_W-1:0]   r_rpl_mac;

    logic                  w_rx_hit;
    logic [LP_PTR_W-1:0]   w_rx_idx;
    logic                  w_chk_hit;
    logic [LP_MAC_W-1:0]   w_chk_mac;
    logic                  w_rsp_match;
    logic                  w_tx_acc;
    logic                  w_timeout;
    logic                  w_retry_left;
    logic                  w_go_rpl;
    logic                  w_go_req;

    // Associative search: receiver IP for cache update, latched IP for lookup
    always_comb begin
        w_rx_hit  = 1'b0;
        w_rx_idx  = '0;
        w_chk_hit = 1'b0;
        w_chk_mac = '0;
        for (int unsigned i = 0; i < LP_ENTRIES; i++) begin
            if (r_cache_v[i] && (r_cache_ip[i] == io_arp.i_rx_ip)) begin
                w_rx_hit = 1'b1;
                w_rx_idx = LP_PTR_W'(i);
            end
            if (r_cache_v[i] && (r_cache_ip[i] == r_ip)) begin
                w_chk_hit = 1'b1;
                w_chk_mac = r_cache_mac[i];
            end
        end
    end

    assign w_rsp_match  = io_arp.i_rx_valid && (io_arp.i_rx_ip == r_ip);
    assign w_tx_acc     = io_arp.o_tx_valid && io_arp.i_tx_ready;
    assign w_timeout    = (r_timer == (P_RETRY_CYCLES - 32'd1));
    assign w_retry_left = (r_retry < LP_RTY_W'(P_MAX_RETRY));

    // A pending reply preempts every decision point that could start a request
    always_comb begin
        w_go_rpl = r_pending && ((r_state == IDLE) || (r_state == CHECK) ||
                                 ((r_state == WAIT_RSP) && !w_rsp_match));
        w_go_req = !r_pending &&
                   (((r_state == CHECK) && !w_chk_hit && !w_rsp_match) ||
                    ((r_state == WAIT_RSP) && !w_rsp_match && w_timeout && w_retry_left));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ret     <= IDLE;
            for (int unsigned i = 0; i < LP_ENTRIES; i++) begin
                r_cache_v[i]   <= 1'b0;
                r_cache_ip[i]  <= '0;
                r_cache_mac[i] <= '0;
            end
            r_ptr     <= '0;
            r_ip      <= '0;
            r_timer   <= '0;
            r_retry   <= '0;
            r_pending <= 1'b0;
            r_rpl_new <= 1'b0;
            r_rpl_ip  <= '0;
            r_rpl_mac <= '0;
            io_arp.o_lookup_ready <= 1'b0;
            io_arp.o_lookup_mac   <= '0;
            io_arp.o_lookup_done  <= 1'b0;
            io_arp.o_lookup_fail  <= 1'b0;
            io_arp.o_tx_valid     <= 1'b0;
            io_arp.o_tx_op        <= '0;
            io_arp.o_tx_dst_ip    <= '0;
            io_arp.o_tx_dst_mac   <= '0;
        end else begin
            io_arp.o_lookup_done <= 1'b0;
            io_arp.o_lookup_fail <= 1'b0;

            if (io_arp.i_rx_valid) begin
                if (w_rx_hit) begin
                    r_cache_mac[w_rx_idx] <= io_arp.i_rx_mac;
                end else begin
                    r_cache_v[r_ptr]   <= 1'b1;
                    r_cache_ip[r_ptr]  <= io_arp.i_rx_ip;
                    r_cache_mac[r_ptr] <= io_arp.i_rx_mac;
                    r_ptr              <= r_ptr + 2'd1;
                end
            end

            if (io_arp.i_trig_reply) begin
                r_rpl_ip  <= io_arp.i_rx_ip;
                r_rpl_mac <= io_arp.i_rx_mac;
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_go_rpl) begin
                        r_state               <= SEND_RPL;
                        io_arp.o_lookup_ready <= 1'b0;
                    end else if (io_arp.i_lookup_valid && io_arp.o_lookup_ready) begin
                        r_ip                  <= io_arp.i_lookup_ip;
                        r_retry               <= '0;
                        io_arp.o_lookup_ready <= 1'b0;
                        io_arp.o_lookup_mac   <= '0;
                        r_state               <= CHECK;
                    end else begin
                        io_arp.o_lookup_ready <= !io_arp.i_trig_reply;
                    end
                end
                CHECK: begin
                    if (w_go_rpl) begin
                        r_state <= SEND_RPL;
                    end else if (w_rsp_match || w_chk_hit) begin
                        r_state              <= DONE;
                        io_arp.o_lookup_done <= 1'b1;
                        io_arp.o_lookup_mac  <= w_rsp_match ? io_arp.i_rx_mac : w_chk_mac;
                    end else begin
                        r_state <= SEND_REQ;
                    end
                end
                SEND_REQ: begin
                    if (w_tx_acc) begin
                        io_arp.o_tx_valid <= 1'b0;
                        r_retry           <= r_retry + LP_RTY_W'(1);
                        r_timer           <= '0;
                        r_state           <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (w_rsp_match) begin
                        r_state              <= DONE;
                        io_arp.o_lookup_done <= 1'b1;
                        io_arp.o_lookup_mac  <= io_arp.i_rx_mac;
                    end else if (w_go_rpl) begin
                        r_state <= SEND_RPL;
                    end else if (w_timeout) begin
                        if (w_retry_left) begin
                            r_state <= SEND_REQ;
                        end else begin
                            r_state              <= DONE;
                            io_arp.o_lookup_fail <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                SEND_RPL: begin
                    // A trigger seen while presenting stays pending for another reply
                    if (w_tx_acc) begin
                        io_arp.o_tx_valid <= 1'b0;
                        r_pending         <= io_arp.i_trig_reply || r_rpl_new;
                        r_rpl_new         <= 1'b0;
                        r_state           <= r_ret;
                        if (r_ret == IDLE) begin
                            io_arp.o_lookup_ready <= !(io_arp.i_trig_reply || r_rpl_new);
                        end
                    end else if (io_arp.i_trig_reply) begin
                        r_rpl_new <= 1'b1;
                    end
                end
                DONE: begin
                    r_state               <= IDLE;
                    io_arp.o_lookup_ready <= !(r_pending || io_arp.i_trig_reply);
                end
                default: r_state <= IDLE;
            endcase

            if (w_go_rpl) begin
                r_ret               <= r_state;
                r_rpl_new           <= io_arp.i_trig_reply;
                io_arp.o_tx_valid   <= 1'b1;
                io_arp.o_tx_op      <= LP_OP_RPL;
                io_arp.o_tx_dst_ip  <= r_rpl_ip;
                io_arp.o_tx_dst_mac <= r_rpl_mac;
            end
            if (w_go_req) begin
                io_arp.o_tx_valid   <= 1'b1;
                io_arp.o_tx_op      <= LP_OP_REQ;
                io_arp.o_tx_dst_ip  <= r_ip;
                io_arp.o_tx_dst_mac <= LP_BCAST;
            end
        end
    end
endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with a 100-cycle retry timer and 3 attempts.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_arp_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    arp_ctrl_if bus ();

    arp_ctrl #(
        .P_RETRY_CYCLES(32'd100),
        .P_MAX_RETRY   (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_arp(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_lookup(input logic [31:0] ip);
        int n = 0;
        while (bus.o_lookup_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (bus.o_lookup_ready !== 1'b1) begin
            bad++;
            $display("FAIL lookup_ready_wait: ready=%b after %0d cycles, want 1", bus.o_lookup_ready, n);
        end
        bus.i_lookup_ip    = ip;
        bus.i_lookup_valid = 1'b1;
        tick();
        bus.i_lookup_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [31:0] ip, input logic [47:0] mac);
        bus.i_rx_ip    = ip;
        bus.i_rx_mac   = mac;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (bus.o_lookup_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.o_lookup_ready); end
        total++; if (bus.o_tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", bus.o_tx_valid); end
        total++; if ({bus.o_lookup_done, bus.o_lookup_fail} !== 2'b00) begin bad++; $display("FAIL rst_pulses: got %b want 00", {bus.o_lookup_done, bus.o_lookup_fail}); end
        total++; if ({bus.o_lookup_mac, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac} !== 144'd0) begin bad++; $display("FAIL rst_data: got %h want 0", {bus.o_lookup_mac, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac}); end
        rst = 1'b0;
        tick();
        total++; if (bus.o_lookup_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", bus.o_lookup_ready); end
    endtask

    task automatic test_miss_resolve();
        bus.i_tx_ready = 1'b1;
        start_lookup(32'hC0A8_0A00);
        tick();
        total++; if ({bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac} !== {1'b1, 16'd1, 32'hC0A8_0A00, BCAST})
            begin bad++; $display("FAIL miss_request: got %b %h %h %h want 1 0001 c0a80a00 ffffffffffff", bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac); end
        tick();
        total++; if (bus.o_tx_valid !== 1'b0) begin bad++; $display("FAIL miss_valid_drop: got %b want 0", bus.o_tx_valid); end
        rx_pulse(32'hC0A8_0A00, 48'h0011_2233_4455);
        total++; if ({bus.o_lookup_done, bus.o_lookup_fail, bus.o_lookup_mac} !== {2'b10, 48'h0011_2233_4455})
            begin bad++; $display("FAIL miss_done: got done=%b fail=%b mac=%h want 1 0 001122334455", bus.o_lookup_done, bus.o_lookup_fail, bus.o_lookup_mac); end
        tick();
        total++; if (bus.o_lookup_done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", bus.o_lookup_done); end
        start_lookup(32'hC0A8_0A00);
        tick();
        total++; if ({bus.o_lookup_done, bus.o_tx_valid, bus.o_lookup_mac} !== {2'b10, 48'h0011_2233_4455})
            begin bad++; $display("FAIL repeat_hit: got done=%b tx=%b mac=%h want 1 0 001122334455", bus.o_lookup_done, bus.o_tx_valid, bus.o_lookup_mac); end
        tick();
    endtask

    task automatic test_timeout();
        int nreq = 0, nfail = 0, ndone = 0, fail_t = -1, badreq = 0;
        int req_t [3];
        req_t = '{-1, -1, -1};
        bus.i_tx_ready = 1'b1;
        start_lookup(32'hC0A8_0A63);
        for (int cyc = 0; cyc < 350; cyc++) begin
            tick();
            if (bus.o_tx_valid === 1'b1) begin
                if (nreq < 3) req_t[nreq] = cyc;
                nreq++;
                if (bus.o_tx_op !== 16'd1 || bus.o_tx_dst_ip !== 32'hC0A8_0A63 || bus.o_tx_dst_mac !== BCAST) badreq++;
            end
            if (bus.o_lookup_fail === 1'b1) begin nfail++; fail_t = cyc; end
            if (bus.o_lookup_done === 1'b1) ndone++;
        end
        total++; if (nreq !== 3) begin bad++; $display("FAIL timeout_req_count: got %0d want 3", nreq); end
        total++; if (badreq !== 0) begin bad++; $display("FAIL timeout_req_fields: got %0d bad requests want 0", badreq); end
        total++; if (req_t[1] - req_t[0] !== 101) begin bad++; $display("FAIL timeout_gap1: got %0d want 101", req_t[1] - req_t[0]); end
        total++; if (req_t[2] - req_t[1] !== 101) begin bad++; $display("FAIL timeout_gap2: got %0d want 101", req_t[2] - req_t[1]); end
        total++; if (nfail !== 1 || ndone !== 0) begin bad++; $display("FAIL timeout_pulses: got fail=%0d done=%0d want 1 0", nfail, ndone); end
        total++; if (fail_t - req_t[2] !== 101) begin bad++; $display("FAIL timeout_fail_time: got %0d want 101", fail_t - req_t[2]); end
    endtask

    task automatic test_reply_wait();
        int early = 0;
        bus.i_tx_ready = 1'b1;
        start_lookup(32'hC0A8_0A77);
        tick();
        total++; if (bus.o_tx_valid !== 1'b1) begin bad++; $display("FAIL rw_request: got %b want 1", bus.o_tx_valid); end
        tick();
        bus.i_tx_ready = 1'b0;
        repeat (20) tick();
        bus.i_rx_ip      = 32'h0A00_0001;
        bus.i_rx_mac     = 48'hAABB_CCDD_EEFF;
        bus.i_trig_reply = 1'b1;
        tick();
        bus.i_trig_reply = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac} !== {1'b1, 16'd2, 32'h0A00_0001, 48'hAABB_CCDD_EEFF})
                begin bad++; $display("FAIL rw_reply_stable[%0d]: got %b %h %h %h want 1 0002 0a000001 aabbccddeeff", i, bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac); end
            if (i < 9) tick();
        end
        bus.i_tx_ready = 1'b1;
        tick();
        total++; if (bus.o_tx_valid !== 1'b0) begin bad++; $display("FAIL rw_reply_accept: got %b want 0", bus.o_tx_valid); end
        for (int i = 0; i < 73; i++) begin
            tick();
            if (bus.o_tx_valid === 1'b1) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL rw_timer_paused: got %0d early requests want 0", early); end
        rx_pulse(32'hC0A8_0A77, 48'h0200_0000_0077);
        total++; if ({bus.o_lookup_done, bus.o_lookup_mac} !== {1'b1, 48'h0200_0000_0077})
            begin bad++; $display("FAIL rw_done: got done=%b mac=%h want 1 020000000077", bus.o_lookup_done, bus.o_lookup_mac); end
        tick();
    endtask

    task automatic test_replacement();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) rx_pulse(32'h0A00_0010 + 32'(i), 48'h0A0A_0000_0010 + 48'(i));
        start_lookup(32'h0A00_0011);
        tick();
        total++; if ({bus.o_lookup_done, bus.o_tx_valid, bus.o_lookup_mac} !== {2'b10, 48'h0A0A_0000_0011})
            begin bad++; $display("FAIL repl_hit11: got done=%b tx=%b mac=%h want 1 0 0a0a00000011", bus.o_lookup_done, bus.o_tx_valid, bus.o_lookup_mac); end
        bus.i_tx_ready = 1'b1;
        start_lookup(32'h0A00_0010);
        tick();
        total++; if ({bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip} !== {1'b1, 16'd1, 32'h0A00_0010})
            begin bad++; $display("FAIL repl_evicted_miss: got %b %h %h want 1 0001 0a000010", bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip); end
        tick();
        rx_pulse(32'h0A00_0010, 48'h0B0B_0000_0010);
        total++; if ({bus.o_lookup_done, bus.o_lookup_mac} !== {1'b1, 48'h0B0B_0000_0010})
            begin bad++; $display("FAIL repl_resolve10: got done=%b mac=%h want 1 0b0b00000010", bus.o_lookup_done, bus.o_lookup_mac); end
        tick();
        rx_pulse(32'h0A00_0012, 48'h0C0C_0000_0012);
        start_lookup(32'h0A00_0012);
        tick();
        total++; if ({bus.o_lookup_done, bus.o_lookup_mac} !== {1'b1, 48'h0C0C_0000_0012})
            begin bad++; $display("FAIL repl_update12: got done=%b mac=%h want 1 0c0c00000012", bus.o_lookup_done, bus.o_lookup_mac); end
        start_lookup(32'h0A00_0013);
        tick();
        total++; if ({bus.o_lookup_done, bus.o_lookup_mac} !== {1'b1, 48'h0A0A_0000_0013})
            begin bad++; $display("FAIL repl_keep13: got done=%b mac=%h want 1 0a0a00000013", bus.o_lookup_done, bus.o_lookup_mac); end
        tick();
    endtask

    task automatic test_simultaneous();
        int n = 0;
        bus.i_tx_ready = 1'b0;
        while (bus.o_lookup_ready !== 1'b1 && n < 20) begin tick(); n++; end
        bus.i_rx_ip        = 32'h0A00_0099;
        bus.i_rx_mac       = 48'hCAFE_0000_0099;
        bus.i_trig_reply   = 1'b1;
        bus.i_lookup_ip    = 32'h0A00_0013;
        bus.i_lookup_valid = 1'b1;
        tick();
        bus.i_trig_reply   = 1'b0;
        bus.i_lookup_valid = 1'b0;
        tick();
        total++; if ({bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac} !== {1'b1, 16'd2, 32'h0A00_0099, 48'hCAFE_0000_0099})
            begin bad++; $display("FAIL sim_reply_first: got %b %h %h %h want 1 0002 0a000099 cafe00000099", bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip, bus.o_tx_dst_mac); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({bus.o_lookup_ready, bus.o_lookup_done, bus.o_tx_valid} !== 3'b001)
                begin bad++; $display("FAIL sim_hold[%0d]: got ready=%b done=%b tx=%b want 0 0 1", i, bus.o_lookup_ready, bus.o_lookup_done, bus.o_tx_valid); end
        end
        bus.i_tx_ready = 1'b1;
        tick();
        total++; if ({bus.o_tx_valid, bus.o_lookup_done} !== 2'b00) begin bad++; $display("FAIL sim_reply_accept: got tx=%b done=%b want 0 0", bus.o_tx_valid, bus.o_lookup_done); end
        tick();
        total++; if ({bus.o_lookup_done, bus.o_lookup_mac} !== {1'b1, 48'h0A0A_0000_0013})
            begin bad++; $display("FAIL sim_lookup_after: got done=%b mac=%h want 1 0a0a00000013", bus.o_lookup_done, bus.o_lookup_mac); end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.i_tx_ready = 1'b0;
        start_lookup(32'h0A00_00AA);
        tick();
        total++; if (bus.o_tx_valid !== 1'b1) begin bad++; $display("FAIL mid_in_send_req: got %b want 1", bus.o_tx_valid); end
        rst = 1'b1;
        #1;
        total++; if ({bus.o_tx_valid, bus.o_lookup_ready} !== 2'b00) begin bad++; $display("FAIL mid_async_clear: got tx=%b ready=%b want 0 0", bus.o_tx_valid, bus.o_lookup_ready); end
        repeat (3) begin
            tick();
            if (bus.o_lookup_done === 1'b1 || bus.o_lookup_fail === 1'b1) pulses++;
        end
        rst = 1'b0;
        tick();
        if (bus.o_lookup_done === 1'b1 || bus.o_lookup_fail === 1'b1) pulses++;
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_pulse: got %0d pulses want 0", pulses); end
        total++; if (bus.o_lookup_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", bus.o_lookup_ready); end
        start_lookup(32'h0A00_0013);
        tick();
        total++; if ({bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip} !== {1'b1, 16'd1, 32'h0A00_0013})
            begin bad++; $display("FAIL mid_cache_cleared: got %b %h %h want 1 0001 0a000013", bus.o_tx_valid, bus.o_tx_op, bus.o_tx_dst_ip); end
        bus.i_tx_ready = 1'b1;
        tick();
        rx_pulse(32'h0A00_0013, 48'h0D0D_0000_0013);
        total++; if ({bus.o_lookup_done, bus.o_lookup_mac} !== {1'b1, 48'h0D0D_0000_0013})
            begin bad++; $display("FAIL mid_resolve: got done=%b mac=%h want 1 0d0d00000013", bus.o_lookup_done, bus.o_lookup_mac); end
        tick();
    endtask

    initial begin
        bus.i_rx_mac       = '0;
        bus.i_rx_ip        = '0;
        bus.i_rx_valid     = 1'b0;
        bus.i_trig_reply   = 1'b0;
        bus.i_lookup_ip    = '0;
        bus.i_lookup_valid = 1'b0;
        bus.i_tx_ready     = 1'b0;
        test_reset();
        test_miss_resolve();
        test_timeout();
        test_reply_wait();
        test_replacement();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
